// File: rtl/ts_packet_mux.sv
// N-channel MPEG-2 TS selector: packet-aligned channel switching, length checking,
// whole-packet drop on overflow and a first-word-fall-through output FIFO.
module ts_packet_mux #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int PKT_LEN    = 188,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            valid_in,
    input  logic [NUM_CH-1:0]            sync_in,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_sync,
    output logic                         out_valid,
    output logic [SEL_W-1:0]             active_ch,
    output logic                         locked,
    output logic [ADDR_WIDTH:0]          fifo_level,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [CNT_W-1:0]             ovf_cnt
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int BCNT_W = $clog2(PKT_LEN + 1);
    localparam logic [BCNT_W-1:0] PKT_LEN_C = BCNT_W'(PKT_LEN);

    typedef enum logic [1:0] {HUNT, PASS, DROP} state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        r_active_ch;
    logic [BCNT_W-1:0]       r_byte_cnt;
    logic [CNT_W-1:0]        r_err_cnt;
    logic [CNT_W-1:0]        r_ovf_cnt;
    logic [ADDR_WIDTH:0]     r_wr_ptr;
    logic [ADDR_WIDTH:0]     r_rd_ptr;
    logic [DATA_WIDTH:0]     r_mem [DEPTH];

    logic                    w_sel_v;
    logic                    w_sel_s;
    logic [DATA_WIDTH-1:0]   w_sel_d;
    logic                    w_act_v;
    logic                    w_act_s;
    logic [DATA_WIDTH-1:0]   w_act_d;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_push_data;
    logic                    w_push_sync;
    logic [BCNT_W-1:0]       w_cnt_next;
    logic [DATA_WIDTH:0]     w_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // An out-of-range sel matches no channel, so HUNT simply never sees an event.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_sel_v = 1'b0;
        w_sel_s = 1'b0;
        w_sel_d = '0;
        w_act_v = 1'b0;
        w_act_s = 1'b0;
        w_act_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == SEL_W'(c)) begin
                w_sel_v = valid_in[c];
                w_sel_s = sync_in[c];
                w_sel_d = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (r_active_ch == SEL_W'(c)) begin
                w_act_v = valid_in[c];
                w_act_s = sync_in[c];
                w_act_d = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                        (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_pop      = !w_empty && out_ready;
    assign w_cnt_next = w_act_s ? BCNT_W'(1) : r_byte_cnt + BCNT_W'(1);

    always_comb begin
        w_push      = 1'b0;
        w_push_data = w_act_d;
        w_push_sync = w_act_s;
        case (r_state)
            HUNT: begin
                w_push      = w_sel_v && w_sel_s && !w_full;
                w_push_data = w_sel_d;
                w_push_sync = 1'b1;
            end
            PASS:    w_push = w_act_v && !w_full;
            default: w_push = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_active_ch <= '0;
            r_byte_cnt  <= '0;
            r_err_cnt   <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            case (r_state)
                HUNT: if (w_sel_v && w_sel_s) begin
                    r_active_ch <= sel;
                    r_byte_cnt  <= BCNT_W'(1);
                    if (w_full) begin
                        r_ovf_cnt <= sat_inc(r_ovf_cnt);
                        r_state   <= DROP;
                    end else begin
                        r_state   <= PASS;
                    end
                end
                PASS: if (w_act_v) begin
                    r_byte_cnt <= w_cnt_next;
                    if (w_act_s && r_byte_cnt < PKT_LEN_C)
                        r_err_cnt <= sat_inc(r_err_cnt);
                    if (w_full)
                        r_ovf_cnt <= sat_inc(r_ovf_cnt);
                    if (w_cnt_next == PKT_LEN_C)
                        r_state <= HUNT;
                    else if (w_full)
                        r_state <= DROP;
                end
                DROP: if (w_act_v) begin
                    if (w_act_s) begin
                        r_err_cnt <= sat_inc(r_err_cnt);
                        r_state   <= HUNT;
                    end else begin
                        r_byte_cnt <= w_cnt_next;
                        if (w_cnt_next == PKT_LEN_C)
                            r_state <= HUNT;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    // Full compares the registered pointers, so a push while full is lost even with a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {w_push_sync, w_push_data};
    end

    assign w_head     = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign out_sync   = !w_empty && w_head[DATA_WIDTH];
    assign fifo_level = r_wr_ptr - r_rd_ptr;
    assign active_ch  = r_active_ch;
    assign locked     = (r_state == PASS);
    assign err_cnt    = r_err_cnt;
    assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_ts_packet_mux.sv
// Bench for ts_packet_mux: a per-cycle vector table for FIFO/FSM basics, then
// packet-level sequences checked through an expected-byte queue.
module tb_ts_packet_mux;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int SW     = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [SW-1:0]          sel = '0;
    logic [NUM_CH*DW-1:0]   data_in = '0;
    logic [NUM_CH-1:0]      valid_in = '0;
    logic [NUM_CH-1:0]      sync_in = '0;
    logic                   out_ready = 1'b0;
    logic [DW-1:0]          out_data;
    logic                   out_sync;
    logic                   out_valid;
    logic [SW-1:0]          active_ch;
    logic                   locked;
    logic [4:0]             fifo_level;
    logic [15:0]            err_cnt;
    logic [15:0]            ovf_cnt;

    logic [1:0]             sel3 = '0;
    logic [3*DW-1:0]        data3 = '0;
    logic [2:0]             valid3 = '0;
    logic [2:0]             sync3 = '0;
    logic [DW-1:0]          out_data3;
    logic                   out_sync3;
    logic                   out_valid3;
    logic [1:0]             active_ch3;
    logic                   locked3;
    logic [4:0]             fifo_level3;
    logic [15:0]            err_cnt3;
    logic [15:0]            ovf_cnt3;

    always #5 clk = ~clk;

    ts_packet_mux u_dut (
        .clk(clk), .rst(rst), .sel(sel), .data_in(data_in), .valid_in(valid_in),
        .sync_in(sync_in), .out_ready(out_ready), .out_data(out_data), .out_sync(out_sync),
        .out_valid(out_valid), .active_ch(active_ch), .locked(locked),
        .fifo_level(fifo_level), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
    );

    ts_packet_mux #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .data_in(data3), .valid_in(valid3),
        .sync_in(sync3), .out_ready(1'b0), .out_data(out_data3), .out_sync(out_sync3),
        .out_valid(out_valid3), .active_ch(active_ch3), .locked(locked3),
        .fifo_level(fifo_level3), .err_cnt(err_cnt3), .ovf_cnt(ovf_cnt3)
    );

    int         total = 0;
    int         bad   = 0;
    bit         sb_en = 1'b0;
    logic [8:0] sb_q[$];

    typedef struct {
        logic       v, s, rdy;
        logic [7:0] d;
        logic       e_valid, e_sync, e_locked;
        logic [7:0] e_data;
        logic [4:0] e_level;
        logic [15:0] e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output bytes are compared just before the edge that pops them.
    task automatic tick();
        logic [8:0] exp;
        if (sb_en && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h expected none (t=%0t)", {out_sync, out_data}, $time);
            end else begin
                exp = sb_q.pop_front();
                check("sb_byte", {23'd0, out_sync, out_data}, {23'd0, exp});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Channel ch gets the given byte; other channels carry random non-sync noise.
    task automatic set_inputs(input int ch, input logic v, input logic s, input logic [7:0] d);
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == ch) begin
                valid_in[c]          = v;
                sync_in[c]           = s;
                data_in[c*DW +: DW]  = d;
            end else begin
                valid_in[c]          = 1'($urandom_range(0, 1));
                sync_in[c]           = 1'b0;
                data_in[c*DW +: DW]  = 8'($urandom);
            end
        end
    endtask

    task automatic drive_byte(input int ch, input logic s, input logic [7:0] d);
        set_inputs(ch, 1'b1, s, d);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            set_inputs(-1, 1'b0, 1'b0, 8'h00);
            tick();
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 64 && sb_q.size() != 0; i++)
            idle(1);
        idle(1);
        check("drain_queue", sb_q.size(), 0);
        check("drain_level", {27'd0, fifo_level}, 0);
        check("drain_valid", {31'd0, out_valid}, 0);
    endtask

    // Sends one packet; the first n_exp bytes are expected at the output.
    task automatic send_pkt(input int ch, input int len, input logic [7:0] seed,
                            input int n_exp, input int sw_at, input int new_sel);
        logic       s;
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            if (k == sw_at)
                sel = SW'(new_sel);
            s = (k == 0);
            d = s ? 8'h47 : 8'(seed + 8'(k));
            if (k < n_exp)
                sb_q.push_back({s, d});
            drive_byte(ch, s, d);
            if (k == 0 && n_exp > 0) begin
                check("pkt_locked", {31'd0, locked}, 1);
                check("pkt_active_ch", {30'd0, active_ch}, ch);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},  {31'd0, out_valid}, 0);
        check({tag, "_data"},   {24'd0, out_data}, 0);
        check({tag, "_sync"},   {31'd0, out_sync}, 0);
        check({tag, "_active"}, {30'd0, active_ch}, 0);
        check({tag, "_locked"}, {31'd0, locked}, 0);
        check({tag, "_level"},  {27'd0, fifo_level}, 0);
        check({tag, "_err"},    {16'd0, err_cnt}, 0);
        check({tag, "_ovf"},    {16'd0, ovf_cnt}, 0);
    endtask

    initial begin
        // fields: v s rdy d | valid sync locked data level err
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h47, 1'b1, 1'b1, 1'b1, 8'h47, 5'd1, 16'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b1, 8'h47, 5'd2, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 5'd1, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 8'h13, 5'd1, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 16'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h48, 1'b1, 1'b1, 1'b1, 8'h48, 5'd1, 16'd1};

        rst = 1'b1;
        idle(2);
        check_reset("reset");
        rst = 1'b0;

        sel = 2'd2;
        for (int i = 0; i < 8; i++) begin
            out_ready = vecs[i].rdy;
            set_inputs(2, vecs[i].v, vecs[i].s, vecs[i].d);
            tick();
            check($sformatf("vec%0d_valid", i),  {31'd0, out_valid},  {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d_sync", i),   {31'd0, out_sync},   {31'd0, vecs[i].e_sync});
            check($sformatf("vec%0d_locked", i), {31'd0, locked},     {31'd0, vecs[i].e_locked});
            check($sformatf("vec%0d_data", i),   {24'd0, out_data},   {24'd0, vecs[i].e_data});
            check($sformatf("vec%0d_level", i),  {27'd0, fifo_level}, {27'd0, vecs[i].e_level});
            check($sformatf("vec%0d_err", i),    {16'd0, err_cnt},    {16'd0, vecs[i].e_err});
        end

        // Reset while locked on channel 2 with data in the FIFO.
        rst = 1'b1;
        set_inputs(2, 1'b1, 1'b0, 8'h55);
        tick();
        check_reset("midreset");
        rst = 1'b0;

        sb_en     = 1'b1;
        out_ready = 1'b1;

        // Two back-to-back packets with zero gap.
        sel = 2'd2;
        send_pkt(2, 188, 8'h10, 188, -1, 0);
        check("t1_locked_gap", {31'd0, locked}, 0);
        send_pkt(2, 188, 8'h20, 188, -1, 0);
        drain();
        check("t1_err", {16'd0, err_cnt}, 0);

        // Channel change requested mid-packet.
        send_pkt(2, 188, 8'h30, 188, 50, 1);
        check("t2_active_hold", {30'd0, active_ch}, 2);
        idle(5);
        check("t2_no_write", {27'd0, fifo_level}, 0);
        send_pkt(1, 188, 8'h40, 188, -1, 0);
        drain();

        // Short packet: sync arrives as byte 100.
        sel = 2'd0;
        send_pkt(0, 99, 8'h50, 99, -1, 0);
        send_pkt(0, 188, 8'h60, 188, -1, 0);
        check("t3_err", {16'd0, err_cnt}, 1);
        check("t3_locked", {31'd0, locked}, 0);
        send_pkt(0, 188, 8'h70, 188, -1, 0);
        drain();
        check("t3_err_after", {16'd0, err_cnt}, 1);

        // Overflow with a stalled consumer.
        sel       = 2'd3;
        out_ready = 1'b0;
        send_pkt(3, 188, 8'h80, 16, -1, 0);
        check("t4_level", {27'd0, fifo_level}, 16);
        check("t4_ovf", {16'd0, ovf_cnt}, 1);
        check("t4_locked", {31'd0, locked}, 0);
        send_pkt(3, 188, 8'h88, 0, -1, 0);
        check("t4_ovf_full_hunt", {16'd0, ovf_cnt}, 2);
        check("t4_level_hold", {27'd0, fifo_level}, 16);
        drain();
        send_pkt(3, 188, 8'h90, 188, -1, 0);
        drain();
        check("t4_ovf_after", {16'd0, ovf_cnt}, 2);

        // Full FIFO with push and pop on the same edge.
        sel       = 2'd1;
        out_ready = 1'b0;
        send_pkt(1, 16, 8'hA0, 16, -1, 0);
        check("t6_level_full", {27'd0, fifo_level}, 16);
        out_ready = 1'b1;
        drive_byte(1, 1'b0, 8'hEE);
        check("t6_level_pop", {27'd0, fifo_level}, 15);
        check("t6_ovf", {16'd0, ovf_cnt}, 3);
        for (int k = 17; k < 188; k++)
            drive_byte(1, 1'b0, 8'(k));
        check("t6_locked", {31'd0, locked}, 0);
        drain();
        send_pkt(1, 188, 8'hB0, 188, -1, 0);
        drain();
        check("t6_ovf_after", {16'd0, ovf_cnt}, 3);
        check("t6_err_after", {16'd0, err_cnt}, 1);

        // Out-of-range select on a 3-channel instance.
        sel3   = 2'd3;
        valid3 = 3'b111;
        sync3  = 3'b111;
        data3  = 24'h474747;
        idle(4);
        check("t5_locked", {31'd0, locked3}, 0);
        check("t5_level", {27'd0, fifo_level3}, 0);
        check("t5_valid", {31'd0, out_valid3}, 0);
        sel3 = 2'd1;
        idle(1);
        check("t5_sel_ok_locked", {31'd0, locked3}, 1);
        check("t5_sel_ok_active", {30'd0, active_ch3}, 1);
        check("t5_sel_ok_level", {27'd0, fifo_level3}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
